// File: rtl/thread_tx_mpu.sv
// Host-side thread transmitter: frames one thread (length word, thread ID, instruction
// stream) from the host program buffer onto the MPU store interface.
module thread_tx_mpu #(
  parameter int WIDTH_INSTR = 32,
  parameter int WIDTH_ADDR  = 10,
  parameter int WIDTH_ID    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Start,
  input  logic [WIDTH_ID-1:0]    I_ThreadID,
  input  logic [WIDTH_ADDR:0]    I_Length,
  input  logic [WIDTH_ADDR-1:0]  I_Base,
  output logic                   O_Busy,
  output logic                   O_Done,
  output logic                   O_Rd_Req,
  output logic [WIDTH_ADDR-1:0]  O_Rd_Addr,
  input  logic [WIDTH_INSTR-1:0] I_Rd_Data,
  output logic                   O_Req_St,
  output logic [WIDTH_INSTR-1:0] O_Instr_St,
  input  logic                   I_Wait,
  input  logic                   I_Ack_St
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_CHK    = 3'd2,
    S_SETUP  = 3'd3,
    S_ID     = 3'd4,
    S_LOOKUP = 3'd5,
    S_STREAM = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [WIDTH_ADDR:0]   CNT_ZERO  = {(WIDTH_ADDR+1){1'b0}};
  localparam logic [WIDTH_ADDR:0]   CNT_ONE   = {{WIDTH_ADDR{1'b0}}, 1'b1};
  localparam logic [WIDTH_ADDR-1:0] ADDR_ZERO = {WIDTH_ADDR{1'b0}};
  localparam logic [WIDTH_ADDR-1:0] ADDR_ONE  = {{(WIDTH_ADDR-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_INSTR-1:0] WORD_ZERO = {WIDTH_INSTR{1'b0}};

  state_t                  state_r;
  state_t                  state_s;
  logic [WIDTH_ID-1:0]     id_r;
  logic [WIDTH_ADDR:0]     len_r;
  logic [WIDTH_ADDR-1:0]   base_r;
  logic [WIDTH_ADDR:0]     remain_r;
  logic [WIDTH_ADDR-1:0]   addr_r;

  logic [WIDTH_ADDR:0]     len_m1_s;
  logic [WIDTH_INSTR-1:0]  len_word_s;
  logic [WIDTH_INSTR-1:0]  id_word_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    rd_req_s;
  logic [WIDTH_ADDR-1:0]   rd_addr_s;
  logic                    req_st_s;
  logic [WIDTH_INSTR-1:0]  instr_s;

  // The MPU stores length+1 words, so the length word carries N-1.
  assign len_m1_s   = len_r - CNT_ONE;
  assign len_word_s = WIDTH_INSTR'(len_m1_s);
  assign id_word_s  = WIDTH_INSTR'(id_r);

  // Next-state and output decode; read data is forwarded straight onto the store bus.
  always_comb begin
    state_s   = state_r;
    busy_s    = 1'b1;
    done_s    = 1'b0;
    rd_req_s  = 1'b0;
    rd_addr_s = ADDR_ZERO;
    req_st_s  = 1'b0;
    instr_s   = WORD_ZERO;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
        if (I_Start && (I_Length != CNT_ZERO)) begin
          state_s = S_LEN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LEN: begin
        req_st_s = 1'b1;
        instr_s  = len_word_s;
        state_s  = S_CHK;
      end
      S_CHK: begin
        req_st_s = 1'b1;
        instr_s  = len_word_s;
        if (I_Wait) begin
          state_s = S_CHK;
        end else begin
          state_s = S_SETUP;
        end
      end
      S_SETUP: begin
        state_s = S_ID;
      end
      S_ID: begin
        req_st_s = 1'b1;
        instr_s  = id_word_s;
        state_s  = S_LOOKUP;
      end
      S_LOOKUP: begin
        req_st_s = 1'b1;
        instr_s  = id_word_s;
        if (I_Ack_St) begin
          rd_req_s  = 1'b1;
          rd_addr_s = base_r;
          state_s   = S_STREAM;
        end else begin
          state_s = S_LOOKUP;
        end
      end
      S_STREAM: begin
        req_st_s = 1'b1;
        instr_s  = I_Rd_Data;
        // The word in flight on the last cycle was already read; no further read.
        if (remain_r > CNT_ONE) begin
          rd_req_s  = 1'b1;
          rd_addr_s = addr_r;
          state_s   = S_STREAM;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  assign O_Busy     = busy_s;
  assign O_Done     = done_s;
  assign O_Rd_Req   = rd_req_s;
  assign O_Rd_Addr  = rd_addr_s;
  assign O_Req_St   = req_st_s;
  assign O_Instr_St = instr_s;

  // State register and frame context: latched on start, counted down while streaming.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= S_IDLE;
      id_r     <= {WIDTH_ID{1'b0}};
      len_r    <= CNT_ZERO;
      base_r   <= ADDR_ZERO;
      remain_r <= CNT_ZERO;
      addr_r   <= ADDR_ZERO;
    end else begin
      state_r <= state_s;
      case (state_r)
        S_IDLE: begin
          if (I_Start && (I_Length != CNT_ZERO)) begin
            id_r   <= I_ThreadID;
            len_r  <= I_Length;
            base_r <= I_Base;
          end
        end
        S_LOOKUP: begin
          if (I_Ack_St) begin
            remain_r <= len_r;
            addr_r   <= base_r + ADDR_ONE;
          end
        end
        S_STREAM: begin
          // Address wraps modulo the buffer size.
          remain_r <= remain_r - CNT_ONE;
          addr_r   <= addr_r + ADDR_ONE;
        end
        default: begin
          remain_r <= remain_r;
          addr_r   <= addr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thread_tx_mpu.sv
// Directed self-checking bench for thread_tx_mpu: frame timing, wait/ack stretching,
// address wrap, ignored starts, mid-frame reset and the maximum thread length.
module tb_thread_tx_mpu;
  localparam int WI = 32;
  localparam int WA = 10;
  localparam int WD = 32;
  localparam int MAXC = 1100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          I_Start = 1'b0;
  logic [WD-1:0] I_ThreadID = '0;
  logic [WA:0]   I_Length = '0;
  logic [WA-1:0] I_Base = '0;
  logic          O_Busy, O_Done, O_Rd_Req, O_Req_St;
  logic [WA-1:0] O_Rd_Addr;
  logic [WI-1:0] I_Rd_Data = 32'hDEAD_BEEF;
  logic [WI-1:0] O_Instr_St;
  logic          I_Wait = 1'b0;
  logic          I_Ack_St = 1'b0;

  int errors = 0;
  int checks = 0;

  logic          c_busy [MAXC];
  logic          c_done [MAXC];
  logic          c_rdreq[MAXC];
  logic          c_req  [MAXC];
  logic [WA-1:0] c_addr [MAXC];
  logic [WI-1:0] c_instr[MAXC];

  always #5 clock = ~clock;

  thread_tx_mpu #(.WIDTH_INSTR(WI), .WIDTH_ADDR(WA), .WIDTH_ID(WD)) dut (
    .clock(clock), .reset(reset), .I_Start(I_Start), .I_ThreadID(I_ThreadID),
    .I_Length(I_Length), .I_Base(I_Base), .O_Busy(O_Busy), .O_Done(O_Done),
    .O_Rd_Req(O_Rd_Req), .O_Rd_Addr(O_Rd_Addr), .I_Rd_Data(I_Rd_Data),
    .O_Req_St(O_Req_St), .O_Instr_St(O_Instr_St), .I_Wait(I_Wait), .I_Ack_St(I_Ack_St)
  );

  function automatic logic [WI-1:0] mem_word(input logic [WA-1:0] a);
    return {16'hA5C3, 6'd0, a};
  endfunction

  // Program buffer: one-cycle read latency, junk when not read.
  always @(posedge clock) begin
    if (O_Rd_Req) I_Rd_Data <= mem_word(O_Rd_Addr);
    else          I_Rd_Data <= 32'hDEAD_BEEF;
  end

  // Drives one start at k=0 and records every cycle's outputs; no checking here.
  task automatic run_frame(input logic [WD-1:0] id, input logic [WA:0] n, input logic [WA-1:0] base,
                           input int wait_n, input int ack_delay, input int extra_start,
                           input int reset_at, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clock); #1;
      reset   = (k == reset_at);
      I_Start = (k == 0) || (k == extra_start);
      if (k == 0) begin
        I_ThreadID = id; I_Length = n; I_Base = base;
      end else if (k == extra_start) begin
        I_ThreadID = 32'h9; I_Length = 11'd2; I_Base = 10'h0;
      end
      I_Wait   = (k >= 2) && (k < 2 + wait_n);
      I_Ack_St = (k == 5 + wait_n + ack_delay);
      #1;
      c_busy[k] = O_Busy;  c_done[k] = O_Done;  c_rdreq[k] = O_Rd_Req;
      c_req[k]  = O_Req_St; c_addr[k] = O_Rd_Addr; c_instr[k] = O_Instr_St;
    end
    I_Start = 1'b0; I_Wait = 1'b0; I_Ack_St = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; I_Start = 1'b1; I_Length = 11'd4;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (O_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", O_Busy); end
    checks++; if (O_Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", O_Done); end
    checks++; if (O_Rd_Req !== 1'b0) begin errors++; $display("FAIL reset_rdreq got=%b exp=0", O_Rd_Req); end
    checks++; if (O_Rd_Addr !== 10'd0) begin errors++; $display("FAIL reset_rdaddr got=%h exp=0", O_Rd_Addr); end
    checks++; if (O_Req_St !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", O_Req_St); end
    checks++; if (O_Instr_St !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", O_Instr_St); end
    I_Start = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_basic();
    logic ereq, edone, ebusy, erd;
    logic [WI-1:0] ei;
    logic [WA-1:0] ea;
    run_frame(32'h5, 11'd4, 10'h10, 0, 0, -1, -1, 14);
    for (int k = 0; k < 14; k++) begin
      ereq  = (k >= 1) && (k <= 9) && (k != 3);
      edone = (k == 10);
      ebusy = (k >= 1) && (k <= 10);
      erd   = (k >= 5) && (k <= 8);
      ea    = erd ? 10'(32'h10 + k - 5) : 10'd0;
      if (k == 1 || k == 2)      ei = 32'd3;
      else if (k == 4 || k == 5) ei = 32'd5;
      else if (k >= 6 && k <= 9) ei = mem_word(10'(32'h10 + k - 6));
      else                       ei = 32'd0;
      checks++; if (c_req[k] !== ereq) begin errors++; $display("FAIL basic_req k=%0d got=%b exp=%b", k, c_req[k], ereq); end
      checks++; if (c_instr[k] !== ei) begin errors++; $display("FAIL basic_instr k=%0d got=%h exp=%h", k, c_instr[k], ei); end
      checks++; if (c_done[k] !== edone) begin errors++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, c_done[k], edone); end
      checks++; if (c_busy[k] !== ebusy) begin errors++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, c_busy[k], ebusy); end
      checks++; if (c_rdreq[k] !== erd) begin errors++; $display("FAIL basic_rdreq k=%0d got=%b exp=%b", k, c_rdreq[k], erd); end
      checks++; if (c_addr[k] !== ea) begin errors++; $display("FAIL basic_rdaddr k=%0d got=%h exp=%h", k, c_addr[k], ea); end
    end
  endtask

  task automatic test_wait();
    logic ereq, edone, ebusy;
    logic [WI-1:0] ei;
    run_frame(32'h5, 11'd4, 10'h10, 3, 0, -1, -1, 16);
    for (int k = 0; k < 16; k++) begin
      ereq  = (k >= 1) && (k <= 12) && (k != 6);
      edone = (k == 13);
      ebusy = (k >= 1) && (k <= 13);
      if (k >= 1 && k <= 5)       ei = 32'd3;
      else if (k == 7 || k == 8)  ei = 32'd5;
      else if (k >= 9 && k <= 12) ei = mem_word(10'(32'h10 + k - 9));
      else                        ei = 32'd0;
      checks++; if (c_req[k] !== ereq) begin errors++; $display("FAIL wait_req k=%0d got=%b exp=%b", k, c_req[k], ereq); end
      checks++; if (c_instr[k] !== ei) begin errors++; $display("FAIL wait_instr k=%0d got=%h exp=%h", k, c_instr[k], ei); end
      checks++; if (c_done[k] !== edone) begin errors++; $display("FAIL wait_done k=%0d got=%b exp=%b", k, c_done[k], edone); end
      checks++; if (c_busy[k] !== ebusy) begin errors++; $display("FAIL wait_busy k=%0d got=%b exp=%b", k, c_busy[k], ebusy); end
    end
  endtask

  task automatic test_ack_delay();
    logic ereq, edone, erd;
    logic [WI-1:0] ei;
    logic [WA-1:0] ea;
    int nrd;
    nrd = 0;
    run_frame(32'hCAFE_0001, 11'd1, 10'h20, 0, 5, -1, -1, 15);
    for (int k = 0; k < 15; k++) begin
      ereq  = (k >= 1) && (k <= 11) && (k != 3);
      edone = (k == 12);
      erd   = (k == 10);
      ea    = erd ? 10'h20 : 10'd0;
      if (k == 1 || k == 2)       ei = 32'd0;
      else if (k >= 4 && k <= 10) ei = 32'hCAFE_0001;
      else if (k == 11)           ei = mem_word(10'h20);
      else                        ei = 32'd0;
      if (c_rdreq[k]) nrd++;
      checks++; if (c_req[k] !== ereq) begin errors++; $display("FAIL ack_req k=%0d got=%b exp=%b", k, c_req[k], ereq); end
      checks++; if (c_instr[k] !== ei) begin errors++; $display("FAIL ack_instr k=%0d got=%h exp=%h", k, c_instr[k], ei); end
      checks++; if (c_done[k] !== edone) begin errors++; $display("FAIL ack_done k=%0d got=%b exp=%b", k, c_done[k], edone); end
      checks++; if (c_rdreq[k] !== erd) begin errors++; $display("FAIL ack_rdreq k=%0d got=%b exp=%b", k, c_rdreq[k], erd); end
      checks++; if (c_addr[k] !== ea) begin errors++; $display("FAIL ack_rdaddr k=%0d got=%h exp=%h", k, c_addr[k], ea); end
    end
    checks++; if (nrd !== 1) begin errors++; $display("FAIL ack_read_count got=%0d exp=1", nrd); end
  endtask

  task automatic test_wrap();
    logic [WA-1:0] ea;
    logic [WI-1:0] ei;
    run_frame(32'h5, 11'd4, 10'd1022, 0, 0, -1, -1, 12);
    for (int k = 5; k <= 8; k++) begin
      ea = 10'(32'd1022 + k - 5);
      checks++; if (c_rdreq[k] !== 1'b1) begin errors++; $display("FAIL wrap_rdreq k=%0d got=%b exp=1", k, c_rdreq[k]); end
      checks++; if (c_addr[k] !== ea) begin errors++; $display("FAIL wrap_rdaddr k=%0d got=%0d exp=%0d", k, c_addr[k], ea); end
    end
    for (int k = 6; k <= 9; k++) begin
      ei = mem_word(10'(32'd1022 + k - 6));
      checks++; if (c_instr[k] !== ei) begin errors++; $display("FAIL wrap_instr k=%0d got=%h exp=%h", k, c_instr[k], ei); end
    end
    checks++; if (c_done[10] !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b exp=1", c_done[10]); end
  endtask

  task automatic test_ignored_starts();
    int ndone;
    logic [WI-1:0] ei;
    ndone = 0;
    @(posedge clock); #1;
    I_Start = 1'b1; I_Length = 11'd0; I_ThreadID = 32'd77; I_Base = 10'h3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      I_Start = 1'b0;
      #1;
      checks++; if (O_Busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy k=%0d got=%b exp=0", k, O_Busy); end
      checks++; if (O_Done !== 1'b0) begin errors++; $display("FAIL zero_len_done k=%0d got=%b exp=0", k, O_Done); end
    end
    run_frame(32'h5, 11'd4, 10'h10, 0, 0, 7, -1, 20);
    for (int k = 0; k < 20; k++) if (c_done[k]) ndone++;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_done_count got=%0d exp=1", ndone); end
    checks++; if (c_done[10] !== 1'b1) begin errors++; $display("FAIL busy_start_done_k10 got=%b exp=1", c_done[10]); end
    checks++; if (c_busy[12] !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b exp=0", c_busy[12]); end
    checks++; if (c_instr[4] !== 32'd5) begin errors++; $display("FAIL busy_start_id got=%h exp=5", c_instr[4]); end
    for (int k = 6; k <= 9; k++) begin
      ei = mem_word(10'(32'h10 + k - 6));
      checks++; if (c_instr[k] !== ei) begin errors++; $display("FAIL busy_start_instr k=%0d got=%h exp=%h", k, c_instr[k], ei); end
    end
  endtask

  task automatic test_reset_mid();
    logic [WI-1:0] ei;
    run_frame(32'h7, 11'd8, 10'h40, 0, 0, -1, 7, 20);
    checks++; if (c_instr[7] !== mem_word(10'h41)) begin errors++; $display("FAIL rst_mid_pre got=%h exp=%h", c_instr[7], mem_word(10'h41)); end
    for (int k = 8; k < 20; k++) begin
      checks++;
      if (c_busy[k] !== 1'b0 || c_done[k] !== 1'b0 || c_rdreq[k] !== 1'b0 ||
          c_req[k] !== 1'b0 || c_addr[k] !== 10'd0 || c_instr[k] !== 32'd0) begin
        errors++;
        $display("FAIL rst_mid_outputs k=%0d got busy=%b done=%b rd=%b addr=%h req=%b instr=%h exp all 0",
                 k, c_busy[k], c_done[k], c_rdreq[k], c_addr[k], c_req[k], c_instr[k]);
      end
    end
    run_frame(32'h5, 11'd4, 10'h10, 0, 0, -1, -1, 12);
    checks++; if (c_instr[1] !== 32'd3) begin errors++; $display("FAIL rst_fresh_len got=%h exp=3", c_instr[1]); end
    checks++; if (c_done[10] !== 1'b1) begin errors++; $display("FAIL rst_fresh_done got=%b exp=1", c_done[10]); end
    for (int k = 6; k <= 9; k++) begin
      ei = mem_word(10'(32'h10 + k - 6));
      checks++; if (c_instr[k] !== ei) begin errors++; $display("FAIL rst_fresh_instr k=%0d got=%h exp=%h", k, c_instr[k], ei); end
    end
  endtask

  task automatic test_max_len();
    run_frame(32'h1, 11'd1024, 10'h0, 0, 0, -1, -1, 1035);
    checks++; if (c_instr[1] !== 32'h3FF) begin errors++; $display("FAIL max_len_word got=%h exp=3ff", c_instr[1]); end
    checks++; if (c_instr[6] !== mem_word(10'd0)) begin errors++; $display("FAIL max_first got=%h exp=%h", c_instr[6], mem_word(10'd0)); end
    checks++; if (c_rdreq[1028] !== 1'b1 || c_addr[1028] !== 10'd1023) begin errors++; $display("FAIL max_last_read got=%b/%0d exp=1/1023", c_rdreq[1028], c_addr[1028]); end
    checks++; if (c_rdreq[1029] !== 1'b0) begin errors++; $display("FAIL max_no_read got=%b exp=0", c_rdreq[1029]); end
    checks++; if (c_instr[1029] !== mem_word(10'd1023)) begin errors++; $display("FAIL max_last got=%h exp=%h", c_instr[1029], mem_word(10'd1023)); end
    checks++; if (c_done[1029] !== 1'b0 || c_done[1030] !== 1'b1) begin errors++; $display("FAIL max_done got=%b%b exp=01", c_done[1029], c_done[1030]); end
    checks++; if (c_busy[1031] !== 1'b0) begin errors++; $display("FAIL max_idle got=%b exp=0", c_busy[1031]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_ack_delay();
    test_wrap();
    test_ignored_starts();
    test_reset_mid();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
